// File: rtl/simple_fifo_pkg.sv
// Shared constants and helpers for the wide-to-narrow FIFO splitter.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package simple_fifo_pkg;

  localparam int DEF_DATA_IN_WIDTH  = 128;
  localparam int DEF_DATA_OUT_WIDTH = 16;

  // Ceiling log2, used for slice-select and counter widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of narrow slices per wide word.
  function automatic int split_ratio(input int din, input int dout);
    return din / dout;
  endfunction

  // Legal only when the wide word is a power-of-two (>=2) multiple of the slice.
  function automatic bit split_ok(input int din, input int dout);
    int r;
    if (dout <= 0) return 1'b0;
    if ((din % dout) != 0) return 1'b0;
    r = din / dout;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

  localparam int RATIO     = split_ratio(DEF_DATA_IN_WIDTH, DEF_DATA_OUT_WIDTH);
  localparam int SEL_WIDTH = clog2(RATIO);

endpackage

// File: rtl/simple_fifo_ram.sv
// Wide-word storage: DEPTH entries of {last, data}.
// Latency: write lands at the clock edge; read port is combinational.
// Backpressure: none; the caller only strobes wr_en when space exists.
module simple_fifo_ram #(
  parameter int WIDTH      = 129,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Storage carries no reset; content is meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/simple_fifo_splitter.sv
// Wide-to-narrow FIFO: wide words in, narrow slices out, LS slice first.
// Latency: word visible (rd_empty=0) after its write edge; rd_dat registered on the accepting read edge.
// Backpressure: wr_full is an almost-full hint; writes without space are dropped, reads while empty are ignored.
// Optional SIMPLE_FIFO_SPLITTER_ERR_EN adds sticky wr_ovf / rd_udf error flags.
module simple_fifo_splitter
  import simple_fifo_pkg::*;
#(
  parameter  int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter  int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter  int ADDR_WIDTH     = 4,
  parameter  int FULL_SLACK     = 1,
  localparam int SEL_W          = clog2(split_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH)),
  localparam int CNT_W          = ADDR_WIDTH + SEL_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_ena,
  input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
  input  logic                      wr_last,
  output logic                      wr_full,
  input  logic                      rd_ena,
  output logic [DATA_OUT_WIDTH-1:0] rd_dat,
  output logic                      rd_last,
  output logic                      rd_empty,
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
  output logic                      wr_ovf,
  output logic                      rd_udf,
`endif
  output logic [CNT_W-1:0]          rd_dat_cnt
);

  localparam int R     = split_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int W     = DATA_IN_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] SLACK_V = (ADDR_WIDTH + 1)'(FULL_SLACK - 1);
  localparam logic [CNT_W-1:0]    R_V     = CNT_W'(R);
  localparam logic [CNT_W-1:0]    ONE_V   = CNT_W'(1);
  localparam logic [SEL_W-1:0]    SEL_MAX = SEL_W'(R - 1);

  generate
    if (!split_ok(DATA_IN_WIDTH, DATA_OUT_WIDTH) || FULL_SLACK < 1 || FULL_SLACK > DEPTH) begin : g_bad_cfg
      $error("simple_fifo_splitter: illegal width ratio or FULL_SLACK");
    end
  endgenerate

  logic [ADDR_WIDTH:0]      wr_ptr;
  logic [ADDR_WIDTH:0]      rd_ptr;
  logic [ADDR_WIDTH:0]      word_cnt;
  logic [ADDR_WIDTH:0]      free_cnt;
  logic [SEL_W-1:0]         sel;
  logic [W-1:0]             head;
  logic [DATA_OUT_WIDTH-1:0] slices [R];
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     head_done;

  // Space is judged from the registered pointers only, so a read that
  // frees the head word this cycle never makes room for a same-cycle write.
  assign word_cnt  = wr_ptr - rd_ptr;
  assign free_cnt  = DEPTH_V - word_cnt;
  assign wr_acc    = wr_ena && (word_cnt < DEPTH_V);
  assign rd_empty  = (rd_dat_cnt == '0);
  assign rd_acc    = rd_ena && !rd_empty;
  assign head_done = (sel == SEL_MAX);
  assign wr_full   = (free_cnt <= SLACK_V);

  simple_fifo_ram #(
    .WIDTH      (W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_dat  ({wr_last, wr_dat}),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_dat  (head)
  );

  // Head word viewed as an array of slices, index 0 = least significant.
  for (genvar g = 0; g < R; g++) begin : g_slice
    assign slices[g] = head[g*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
  end

  // Write pointer advances on every accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        wr_ptr <= '0;
    else if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
  end

  // Slice selector walks the head word; the word is freed after its last slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      sel    <= '0;
    end else if (rd_acc) begin
      sel <= sel + 1'b1;
      if (head_done) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Slice count: +R per word in, -1 per slice out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_dat_cnt <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   rd_dat_cnt <= rd_dat_cnt + R_V;
        2'b01:   rd_dat_cnt <= rd_dat_cnt - ONE_V;
        2'b11:   rd_dat_cnt <= rd_dat_cnt + R_V - ONE_V;
        default: rd_dat_cnt <= rd_dat_cnt;
      endcase
    end
  end

  // Output slice register; holds its value across rejected reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_dat  <= '0;
      rd_last <= 1'b0;
    end else if (rd_acc) begin
      rd_dat  <= slices[sel];
      rd_last <= head[W-1] & head_done;
    end
  end

`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else begin
      if (wr_ena && !wr_acc) wr_ovf <= 1'b1;
      if (rd_ena && rd_empty) rd_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simple_fifo_splitter.sv
// Bench for simple_fifo_splitter: table vectors, directed corner sequences
// and random traffic against a slice-queue reference model.
module tb_simple_fifo_splitter;

  localparam int DIN   = 128;
  localparam int DOUT  = 16;
  localparam int AW    = 4;
  localparam int R     = DIN / DOUT;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 3 + 1;

  logic            clk;
  logic            rst;
  logic            wr_ena;
  logic [DIN-1:0]  wr_dat;
  logic            wr_last;
  logic            rd_ena;
  logic            wr_full,  wr_full_b;
  logic [DOUT-1:0] rd_dat,   rd_dat_b;
  logic            rd_last,  rd_last_b;
  logic            rd_empty, rd_empty_b;
  logic [CW-1:0]   rd_dat_cnt, rd_dat_cnt_b;
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
  logic            wr_ovf, rd_udf, wr_ovf_b, rd_udf_b;
`endif

  simple_fifo_splitter #(.DATA_IN_WIDTH(DIN), .DATA_OUT_WIDTH(DOUT), .ADDR_WIDTH(AW), .FULL_SLACK(1)) dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_last(wr_last), .wr_full(wr_full),
    .rd_ena(rd_ena), .rd_dat(rd_dat), .rd_last(rd_last), .rd_empty(rd_empty),
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
    .wr_ovf(wr_ovf), .rd_udf(rd_udf),
`endif
    .rd_dat_cnt(rd_dat_cnt)
  );

  // Same stimulus, larger almost-full slack.
  simple_fifo_splitter #(.DATA_IN_WIDTH(DIN), .DATA_OUT_WIDTH(DOUT), .ADDR_WIDTH(AW), .FULL_SLACK(3)) dut_b (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_last(wr_last), .wr_full(wr_full_b),
    .rd_ena(rd_ena), .rd_dat(rd_dat_b), .rd_last(rd_last_b), .rd_empty(rd_empty_b),
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
    .wr_ovf(wr_ovf_b), .rd_udf(rd_udf_b),
`endif
    .rd_dat_cnt(rd_dat_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of pending slices {last, data}.
  logic [DOUT:0]   mq[$];
  logic [DOUT-1:0] m_dat;
  logic            m_last;
  logic            m_ovf, m_udf;
  int tests, fails;

  typedef struct {
    bit              we;
    logic [DIN-1:0]  wd;
    bit              wl;
    bit              re;
    logic [DOUT-1:0] edat;
    bit              elast;
    int              ecnt;
    bit              eempty;
  } vec_t;
  vec_t tv[9];

  function automatic int m_words();
    return (mq.size() + R - 1) / R;
  endfunction

  task automatic chk(input string nm, input logic [DIN-1:0] act, input logic [DIN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dat  = '0;
    m_last = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all();
    chk("rd_dat",     rd_dat,     m_dat);
    chk("rd_last",    rd_last,    m_last);
    chk("rd_dat_cnt", rd_dat_cnt, mq.size());
    chk("rd_empty",   rd_empty,   mq.size() == 0);
    chk("wr_full",    wr_full,    (DEPTH - m_words()) <= 0);
    chk("wr_full_s3", wr_full_b,  (DEPTH - m_words()) <= 2);
    chk("cnt_s3",     rd_dat_cnt_b, mq.size());
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
    chk("wr_ovf", wr_ovf, m_ovf);
    chk("rd_udf", rd_udf, m_udf);
`endif
  endtask

  // One clock cycle of stimulus; model decisions use pre-edge state.
  task automatic step(input bit we, input logic [DIN-1:0] wd, input bit wl, input bit re);
    bit wacc, racc;
    logic [DOUT:0] s;
    wr_ena  = we;
    wr_dat  = wd;
    wr_last = wl;
    rd_ena  = re;
    wacc = we && (m_words() < DEPTH);
    racc = re && (mq.size() != 0);
    if (we && !wacc) m_ovf = 1'b1;
    if (re && mq.size() == 0) m_udf = 1'b1;
    @(posedge clk);
    #1;
    if (racc) begin
      s = mq.pop_front();
      m_dat  = s[DOUT-1:0];
      m_last = s[DOUT];
    end
    if (wacc) begin
      for (int k = 0; k < R; k++) mq.push_back({wl && (k == R - 1), wd[k*DOUT +: DOUT]});
    end
    check_all();
  endtask

  task automatic idle();
    wr_ena = 1'b0;
    rd_ena = 1'b0;
    wr_last = 1'b0;
    wr_dat = '0;
  endtask

  logic [DIN-1:0] w, wa, wb;
  int nlast;

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    rst = 1'b0;
    idle();

    // Slice-order vectors: one word with slice k = k, then 8 pops.
    for (int k = 0; k < R; k++) w[k*DOUT +: DOUT] = DOUT'(k);
    tv[0] = '{we:1, wd:w, wl:0, re:0, edat:16'h0, elast:0, ecnt:8, eempty:0};
    for (int k = 1; k <= R; k++)
      tv[k] = '{we:0, wd:'0, wl:0, re:1, edat:DOUT'(k - 1), elast:0, ecnt:R - k, eempty:(k == R)};

    // Reset values, before any edge.
    #1;
    check_all();
    chk("rst_empty", rd_empty, 1'b1);
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      step(tv[i].we, tv[i].wd, tv[i].wl, tv[i].re);
      chk("tv_dat",   rd_dat,     tv[i].edat);
      chk("tv_last",  rd_last,    tv[i].elast);
      chk("tv_cnt",   rd_dat_cnt, tv[i].ecnt);
      chk("tv_empty", rd_empty,   tv[i].eempty);
    end

    // Pop on empty: rd_dat holds the last delivered slice.
    step(0, '0, 0, 1);
    chk("udf_hold", rd_dat, 16'd7);
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
    chk("udf_flag", rd_udf, 1'b1);
`endif

    // Simultaneous write+read on empty: read rejected, write taken.
    step(1, {DIN{1'b1}}, 0, 1);
    chk("wr_rd_empty_cnt", rd_dat_cnt, 8);
    chk("wr_rd_empty_dat", rd_dat, 16'd7);
    for (int p = 0; p < R; p++) step(0, '0, 0, 1);

    // Fill: 17 words 0..16, full after the 16th, 17th dropped.
    for (int i = 0; i < 17; i++) begin
      step(1, DIN'(i), 0, 0);
      chk("fill_full",    wr_full,   i >= 15);
      chk("fill_full_s3", wr_full_b, i >= 13);
    end
    chk("fill_cnt", rd_dat_cnt, 128);
    chk("fill_cnt_s3", rd_dat_cnt_b, 128);
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
    chk("fill_ovf", wr_ovf, 1'b1);
`endif
    // Full + read: write still dropped although the read pops a slice.
    step(1, DIN'(99), 0, 1);
    chk("full_rd_cnt", rd_dat_cnt, 127);
    for (int p = 1; p < 128; p++) begin
      step(0, '0, 0, 1);
      if (p % R == 0) chk("drain_slice0", rd_dat, DOUT'(p / R));
    end
    chk("drain_empty", rd_empty, 1'b1);

    // Streaming: continuous writes, then continuous reads.
    for (int i = 0; i < 32; i++) step(1, DIN'(9), 0, 0);
    for (int i = 0; i < 32; i++) step(0, '0, 0, 1);
    chk("stream_cnt", rd_dat_cnt, 96);

    // Asynchronous reset mid-drain, checked before any clock edge.
    rd_ena = 1'b1;
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_dat",   rd_dat,     16'h0);
    chk("arst_last",  rd_last,    1'b0);
    chk("arst_cnt",   rd_dat_cnt, 0);
    chk("arst_empty", rd_empty,   1'b1);
    chk("arst_full",  wr_full,    1'b0);
`ifdef SIMPLE_FIFO_SPLITTER_ERR_EN
    chk("arst_ovf", wr_ovf, 1'b0);
    chk("arst_udf", rd_udf, 1'b0);
`endif
    idle();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Packet tag: rd_last only on the final slice of the tagged word.
    wa = {$urandom(), $urandom(), $urandom(), $urandom()};
    wb = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1, wa, 0, 0);
    step(1, wb, 1, 0);
    nlast = 0;
    for (int p = 0; p < 2 * R; p++) begin
      step(0, '0, 0, 1);
      chk("pkt_last", rd_last, p == 2 * R - 1);
      if (rd_last) nlast++;
    end
    chk("pkt_nlast", nlast, 1);
    step(0, '0, 0, 1);
    chk("pkt_udf_hold", rd_dat, wb[DIN-1 -: DOUT]);
    chk("pkt_udf_last", rd_last, 1'b1);

    // Random traffic with phases that lean toward filling or draining.
    for (int i = 0; i < 1200; i++) begin
      int pw, pr;
      pw = ((i / 150) % 2 == 0) ? 70 : 20;
      pr = ((i / 150) % 2 == 0) ? 40 : 90;
      step($urandom_range(99) < pw,
           {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(1),
           $urandom_range(99) < pr);
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_fifo_splitter.md
# simple_fifo_splitter

Wide-to-narrow synchronous FIFO: accepts DATA_IN_WIDTH words on the write side and delivers them as DATA_OUT_WIDTH slices on the read side, least-significant slice first. It is the read-direction counterpart of the narrow-to-wide packing adapter. It sits between a wide internal datapath, such as a 128-bit DMA/memory return, and a narrow consumer or serial stage. Storage is wide-word; a slice selector unloads the head word in place.

## Interface
- DATA_IN_WIDTH, 128, write word width; must equal R·DATA_OUT_WIDTH with R a power of two ≥ 2
- DATA_OUT_WIDTH, 16, read slice width
- ADDR_WIDTH, 4, log2 of wide-word depth (DEPTH = 2^ADDR_WIDTH)
- FULL_SLACK, 1, wr_full asserts when free word slots ≤ FULL_SLACK−1; range 1..DEPTH
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- wr_ena  in  1  write strobe
- wr_dat  in  DATA_IN_WIDTH  write word
- wr_last  in  1  tags the word as end-of-packet
- wr_full  out  1  almost-full/full indication
- rd_ena  in  1  read strobe
- rd_dat  out  DATA_OUT_WIDTH  registered read slice
- rd_last  out  1  registered; 1 with the final slice of a wr_last-tagged word
- rd_empty  out  1  no slices available
- rd_dat_cnt  out  ADDR_WIDTH+log2(R)+1  slices held, excluding slices already delivered

## Operation
- Write is accepted iff wr_ena=1 and word count < DEPTH. It stores {wr_last, wr_dat} at wr_ptr, then wr_ptr+1. Writes with no physical space are dropped without any effect.
- Read is accepted iff rd_ena=1 and rd_empty=0. The slice rd_dat <= head[sel·OUT +: OUT] and rd_last <= head_last & (sel==R−1).
- After each accepted read, sel increments. At sel==R−1, sel wraps to 0 and rd_ptr+1, which frees the word.
- Pointers are ADDR_WIDTH+1 bits with natural wrap. Word count = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1).
- rd_dat_cnt changes as follows: +R on write only, −1 on read only, +R−1 on both. Range is 0..DEPTH·R.
- rd_empty = (rd_dat_cnt==0). wr_full = (DEPTH − word count ≤ FULL_SLACK−1). Both are combinational from registers.
- Rejected reads leave rd_dat and rd_last holding their last values.

## Timing
- Reset (rst=0, asynchronous): ptrs=0, sel=0, rd_dat=0, rd_last=0, rd_dat_cnt=0, rd_empty=1, wr_full=0. Reset mid-transfer discards all content immediately; memory contents are don't-care.
- Write-to-visibility: a word written at edge N gives rd_empty=0 after edge N. Its first slice can be read at edge N+1.
- Read latency: rd_dat is valid after the edge that accepts rd_ena. The sampler reads it after that edge, with no extra cycle.
- Simultaneous write and read on an empty FIFO: the read is rejected and the write is accepted.
- Simultaneous write and read on a full FIFO: the write is dropped. This holds even when the read frees the head word in the same cycle. Space is judged at the start of the cycle.
- Continuous read sustains one slice per cycle. Continuous write sustains one word per cycle until full.

## Configuration
- SIMPLE_FIFO_SPLITTER_ERR_EN defined: adds outputs wr_ovf and rd_udf, each 1 bit, sticky, reset 0.
  - wr_ovf sets on a dropped write.
  - rd_udf sets on rd_ena while rd_empty.
  - Both clear only by reset.
- Not defined: the ports and logic are absent. Dropped writes and rejected reads are silent.

## Structure
- Shared package simple_fifo_pkg holds:
  - clog2 function
  - RATIO = DATA_IN_WIDTH/DATA_OUT_WIDTH and SEL_WIDTH constants
  - elaboration check that DATA_IN_WIDTH is a power-of-two multiple of DATA_OUT_WIDTH
- Sub-module simple_fifo_ram holds the DEPTH×(DATA_IN_WIDTH+1) storage. It has a synchronous write port and an asynchronous read port addressed by rd_ptr[ADDR_WIDTH−1:0].
- Top level holds the pointers, sel, slice counter, flags and output registers.

## Test plan
- **Slice order:** write one word with slice k = k, i.e. 0x0007_0006_0005_0004_0003_0002_0001_0000, then pop 8 times. Expect rd_dat = 0..7 in order, rd_dat_cnt 8→0, and rd_empty=1 after the 8th pop.
- **Fill:** write 17 words with values 0..16. Expect wr_full=1 after the 16th write and the 17th write dropped, with rd_dat_cnt=128. Drain 128 pops; expect the slice-0 values 0..15 at pops 0, 8, …, 120. With ERR_EN, expect wr_ovf=1.
- **Slack:** rebuild with FULL_SLACK=3. Expect wr_full after the 14th write, while writes 15 and 16 are still accepted.
- **Streaming:** hold wr_ena=1 with wr_dat=9 for 32 cycles, then hold rd_ena=1 for 32 cycles. Expect no data loss among accepted words, rd_dat_cnt exactly tracking the +R/−1/+R−1 rule, and every slice 0 except slice 0 of each word = 9.
- **Packet tag:** write word A with wr_last=0 and word B with wr_last=1, then pop 16. Expect rd_last=1 only on the 16th slice.
- **Reset and underflow:** drive rst=0 mid-drain, with no clock edge needed. Expect all outputs at reset values immediately. Then pop while empty: expect rd_dat unchanged and, with ERR_EN, rd_udf=1.
